// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised register file with sequential clear; REGFILE_BYPASS_EN selects write-first reads
module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [AW-1:0]    RDo,
  input  logic             RegWrite,
  input  logic [WIDTH-1:0] Mem_to_Reg,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             ready
);

  localparam logic [0:0]    S_CLEAR  = 1'b0;
  localparam logic [0:0]    S_RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [0:0]       state;
  logic [AW-1:0]    clr_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             zero_wr;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Effective write: only in RUN, and never into the hardwired zero register
  always_comb begin
    zero_wr = (ZERO_REG != 0) && (RDo == '0);
    wr_en   = (state == S_RUN) && RegWrite && !zero_wr;
  end

  // Port A read mux: zero register wins, then optional same-cycle bypass, then array
  always_comb begin
    rd_a = mem[RA];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (RDo == RA)) begin
      rd_a = Mem_to_Reg;
    end
`endif
    if ((ZERO_REG != 0) && (RA == '0)) begin
      rd_a = '0;
    end
  end

  // Port B read mux, same priority as port A so RA==RB always agrees
  always_comb begin
    rd_b = mem[RB];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (RDo == RB)) begin
      rd_b = Mem_to_Reg;
    end
`endif
    if ((ZERO_REG != 0) && (RB == '0)) begin
      rd_b = '0;
    end
  end

  // Control FSM: CLEAR walks every entry once, then RUN serves registered reads
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      A       <= '0;
      B       <= '0;
    end else if (state == S_CLEAR) begin
      A       <= '0;
      B       <= '0;
      clr_cnt <= clr_cnt + AW'(1);
      if (clr_cnt == LAST_IDX) begin
        state <= S_RUN;
        ready <= 1'b1;
      end
    end else begin
      A <= rd_a;
      B <= rd_b;
    end
  end

  // Array storage: not reset directly; zeroed one entry per cycle during CLEAR
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_en) begin
        mem[RDo] <= Mem_to_Reg;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (ZERO_REG=1 and ZERO_REG=0 instances)
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ra = '0, rb = '0, wa = '0;
  logic       we = 1'b0;
  logic [7:0] wd = '0;
  logic [7:0] a1, b1, a0, b0;
  logic       rdy1, rdy0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(8), .DEPTH(8), .AW(3), .ZERO_REG(1)) u_z1 (
    .clk(clk), .rst(rst), .RA(ra), .RB(rb), .RDo(wa), .RegWrite(we),
    .Mem_to_Reg(wd), .A(a1), .B(b1), .ready(rdy1)
  );

  regfile_param #(.WIDTH(8), .DEPTH(8), .AW(3), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst(rst), .RA(ra), .RB(rb), .RDo(wa), .RegWrite(we),
    .Mem_to_Reg(wd), .A(a0), .B(b0), .ready(rdy0)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 1 = ZERO_REG=1 instance, index 0 = ZERO_REG=0 instance
  logic [7:0] m [2][8];
  logic [7:0] ea [2];
  logic [7:0] eb [2];
  bit         erdy = 1'b0;
  bit         seen = 1'b0;
  bit         running = 1'b0;
  int         cleared = 0;

  function automatic logic [7:0] model_read(input int z, input logic [2:0] adr,
                                            input bit w, input logic [2:0] wadr, input logic [7:0] wdat);
    if (z == 1 && adr == 3'd0) return 8'h00;
    if (BYPASS && w && wadr == adr) return wdat;
    return m[z][adr];
  endfunction

  // Compare process: advance the model on every edge, then check both instances
  always @(posedge clk) begin
    logic       s_rst, s_we;
    logic [2:0] s_ra, s_rb, s_wa;
    logic [7:0] s_wd;
    s_rst = rst; s_we = we; s_ra = ra; s_rb = rb; s_wa = wa; s_wd = wd;
    if (s_rst) begin
      seen = 1'b1; running = 1'b0; cleared = 0; erdy = 1'b0;
      for (int z = 0; z < 2; z++) begin ea[z] = 8'h00; eb[z] = 8'h00; end
    end else if (seen && !running) begin
      for (int z = 0; z < 2; z++) begin
        m[z][cleared] = 8'h00; ea[z] = 8'h00; eb[z] = 8'h00;
      end
      cleared++;
      if (cleared == 8) begin running = 1'b1; erdy = 1'b1; end
    end else if (running) begin
      for (int z = 0; z < 2; z++) begin
        ea[z] = model_read(z, s_ra, s_we, s_wa, s_wd);
        eb[z] = model_read(z, s_rb, s_we, s_wa, s_wd);
        if (s_we && !(z == 1 && s_wa == 3'd0)) m[z][s_wa] = s_wd;
      end
    end
    #1;
    if (seen) begin
      chk("model ready z1", {31'd0, rdy1}, {31'd0, erdy});
      chk("model ready z0", {31'd0, rdy0}, {31'd0, erdy});
      chk("model A z1", {24'd0, a1}, {24'd0, ea[1]});
      chk("model B z1", {24'd0, b1}, {24'd0, eb[1]});
      chk("model A z0", {24'd0, a0}, {24'd0, ea[0]});
      chk("model B z0", {24'd0, b0}, {24'd0, eb[0]});
    end
  end

  // Pulse rst for one edge, then count negedge samples with ready low (bounded)
  task automatic reset_and_count(output int n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset ready", {31'd0, rdy1}, 32'd0);
    chk("reset A", {24'd0, a1}, 32'd0);
    n = 1;
    for (int i = 0; i < 30 && !rdy1; i++) begin
      @(negedge clk);
      if (!rdy1) n++;
    end
  endtask

  task automatic write_reg(input logic [2:0] adr, input logic [7:0] dat);
    we = 1'b1; wa = adr; wd = dat;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] adr, input logic [7:0] exp1, input logic [7:0] exp0, input string name);
    ra = adr; rb = adr;
    @(negedge clk);
    chk({name, " A z1"}, {24'd0, a1}, {24'd0, exp1});
    chk({name, " B z1"}, {24'd0, b1}, {24'd0, exp1});
    chk({name, " A z0"}, {24'd0, a0}, {24'd0, exp0});
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);

    // Initial clear, with a write to addr 2 pending throughout CLEAR
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; we = 1'b1; wa = 3'd2; wd = 8'h77;
    chk("reset ready", {31'd0, rdy1}, 32'd0);
    n = 1;
    for (int i = 0; i < 30 && !rdy1; i++) begin
      @(negedge clk);
      if (!rdy1) n++;
    end
    we = 1'b0;
    chk("clear length", n, 32'd8);
    for (int i = 0; i < 8; i++) read_check(3'(i), 8'h00, 8'h00, "post clear");

    // Write then read back on both ports
    write_reg(3'd3, 8'hA5);
    read_check(3'd3, 8'hA5, 8'hA5, "addr3 readback");

    // Zero register behaviour
    write_reg(3'd0, 8'hFF);
    read_check(3'd0, 8'h00, 8'hFF, "addr0");

    // Same-cycle read/write collision
    write_reg(3'd5, 8'h11);
    we = 1'b1; wa = 3'd5; wd = 8'h3C; ra = 3'd5; rb = 3'd5;
    @(negedge clk);
    we = 1'b0;
    chk("collision A", {24'd0, a1}, BYPASS ? 32'h3C : 32'h11);
    read_check(3'd5, 8'h3C, 8'h3C, "after collision");

    // Reset in mid-CLEAR after data existed
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    reset_and_count(n);
    chk("restart clear length", n, 32'd8);
    for (int i = 0; i < 8; i++) read_check(3'(i), 8'h00, 8'h00, "post restart");

    // Randomised traffic with occasional resets, checked by the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      we  = $urandom_range(0, 1);
      wa  = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom_range(0, 7));
      wd  = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; we = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of each register in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, register count, a power of two and at least 2.
REQ-003 The block SHALL have parameter AW, default 3, address width, equal to log2(DEPTH).
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, address 0 reads as zero and ignores writes.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports RA and RB, input, AW bits each: read addresses for port A and port B.
REQ-008 The block SHALL have port RDo, input, AW bits: write address.
REQ-009 The block SHALL have port RegWrite, input, 1 bit: write enable.
REQ-010 The block SHALL have port Mem_to_Reg, input, WIDTH bits: write data.
REQ-011 The block SHALL have ports A and B, output, WIDTH bits each: registered read data.
REQ-012 The block SHALL have port ready, output, 1 bit: high when the sequential clear is complete and writes are accepted.

Function
REQ-013 The block SHALL run a two-state FSM with states CLEAR and RUN.
REQ-014 CLEAR: a clear counter SHALL write zero to entry counter[AW-1:0] on each cycle and increment.
REQ-015 CLEAR SHALL move to RUN on the cycle the counter reaches DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-016 RUN SHALL persist until rst.
REQ-017 ready SHALL be 0 in CLEAR and 1 in RUN, registered.
REQ-018 In CLEAR, RegWrite SHALL be ignored, and A and B SHALL load zero each cycle.
REQ-019 In RUN, A and B SHALL load the contents addressed by RA and RB sampled on the same edge, for a read latency of one cycle.
REQ-020 In RUN, when RegWrite=1, entry RDo SHALL take Mem_to_Reg at the edge.
REQ-021 If ZERO_REG=1 and RDo=0, the write SHALL be discarded.
REQ-022 If ZERO_REG=1, RA=0 or RB=0 SHALL load zero into A or B regardless of array contents or bypass.
REQ-023 If ZERO_REG=0, entry 0 SHALL behave as an ordinary register.
REQ-024 RA=RB SHALL give identical A and B.
REQ-025 A read and a write to the same address in one cycle SHALL follow the bypass rule in Configuration.
REQ-026 Addresses SHALL be used modulo DEPTH with no out-of-range behaviour, since the width is exactly AW.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set state to CLEAR, counter to 0, A and B to 0, and ready to 0.
REQ-028 The clear counter SHALL restart at 0 on an assertion of rst in mid-CLEAR or in RUN.
REQ-029 The array SHALL NOT be cleared in a single cycle; only the CLEAR sequence zeroes it.
REQ-030 Writes in progress on the edge rst is sampled SHALL be discarded.

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined, a RUN-state read of address X in the same cycle as a write to X (RegWrite=1) SHALL load the new Mem_to_Reg into A and/or B (write-first).
REQ-032 With REGFILE_BYPASS_EN undefined, the block SHALL load the old array contents (read-first), with the new value visible from the next read onward.
REQ-033 The ZERO_REG rule SHALL take precedence over bypass in both builds.

Verification
REQ-034 Bench: WIDTH=8, DEPTH=8, rst high 1 cycle then low -> ready=0 for exactly 8 cycles, then 1, and all 8 entries read 0x00.
REQ-035 Bench: in RUN, write 0xA5 to addr 3, next cycle RA=3, RB=3 -> A=B=0xA5 one cycle later.
REQ-036 Bench: ZERO_REG=1, write 0xFF to addr 0, then RA=0 -> A=0x00; with ZERO_REG=0, A=0xFF.
REQ-037 Bench: same-cycle write 0x3C to addr 5 with RA=5, old value 0x11 -> A=0x3C with REGFILE_BYPASS_EN, A=0x11 without; next read 0x3C in both builds.
REQ-038 Bench: rst asserted at CLEAR cycle 4 after nonzero data existed -> counter restarts, ready stays 0 for 8 further cycles, all entries read 0x00.
REQ-039 Bench: RegWrite=1 with 0x77 to addr 2 during CLEAR -> after ready, addr 2 reads 0x00.
